// File: rtl/pixel_frame_sequencer.sv
// Frame buffer and valid/busy feeder for a single-pixel serial NeoPixel writer.
// Streams NUM_PIXELS RGB words in address order, then idles for the latch period.
module pixel_frame_sequencer #(
    parameter int NUM_PIXELS   = 8,
    parameter int ADDR_W       = 3,
    parameter int LATCH_CYCLES = 1200,
    parameter int BUSY_TIMEOUT = 255
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              wr_en,
    input  logic [ADDR_W-1:0] wr_addr,
    input  logic [23:0]       wr_data,
    input  logic              start,
    output logic              frame_busy,
    output logic              done,
    output logic              err,
    output logic              pixel_valid,
    output logic [7:0]        pixel_r,
    output logic [7:0]        pixel_g,
    output logic [7:0]        pixel_b,
    input  logic              pixel_busy
);

    localparam int CNT_MAX = (LATCH_CYCLES > BUSY_TIMEOUT) ? LATCH_CYCLES
                                                           : BUSY_TIMEOUT;
    localparam int CNT_W = $clog2(CNT_MAX + 1);
    localparam int DEPTH = 1 << ADDR_W;

    localparam logic [ADDR_W:0]   NPIX     = (ADDR_W + 1)'(NUM_PIXELS);
    localparam logic [ADDR_W-1:0] LAST_IDX = ADDR_W'(NUM_PIXELS - 1);
    localparam logic [CNT_W-1:0]  TO_LAST  = CNT_W'(BUSY_TIMEOUT - 1);
    localparam logic [CNT_W-1:0]  LAT_LAST = CNT_W'(LATCH_CYCLES - 1);
    localparam logic [CNT_W-1:0]  CNT_ONE  = CNT_W'(1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_LOAD,
        S_PRESENT,
        S_ACK_HI,
        S_ACK_LO,
        S_LATCH,
        S_DONE
    } state_t;

    state_t            state;
    state_t            state_nx;
    logic [ADDR_W-1:0] idx;
    logic [ADDR_W-1:0] idx_nx;
    logic [CNT_W-1:0]  cnt;
    logic [CNT_W-1:0]  cnt_nx;
    logic              err_nx;
    logic [23:0]       pix_q;
    logic [23:0]       mem [DEPTH];
    logic              wr_ok;

    assign wr_ok = wr_en && ({1'b0, wr_addr} < NPIX);

    // Buffer is deliberately not reset; read-before-write on a same-cycle hit.
    always_ff @(posedge clk) begin
        if (wr_ok) begin
            mem[wr_addr] <= wr_data;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pix_q <= '0;
        end else if (state == S_LOAD) begin
            pix_q <= mem[idx];
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= S_IDLE;
            idx   <= '0;
            cnt   <= '0;
            err   <= 1'b0;
        end else begin
            state <= state_nx;
            idx   <= idx_nx;
            cnt   <= cnt_nx;
            err   <= err_nx;
        end
    end

    // cnt holds cycles elapsed since the idle/valid reference cycle,
    // so it is preloaded with 1 on the transition out of that cycle.
    always_comb begin
        state_nx = state;
        idx_nx   = idx;
        cnt_nx   = cnt;
        err_nx   = err;
        unique case (state)
            S_IDLE: begin
                if (start) begin
                    state_nx = S_LOAD;
                    idx_nx   = '0;
                    err_nx   = 1'b0;
                end
            end
            S_LOAD: begin
                state_nx = S_PRESENT;
            end
            S_PRESENT: begin
                state_nx = S_ACK_HI;
                cnt_nx   = CNT_ONE;
            end
            S_ACK_HI: begin
                if (pixel_busy) begin
                    state_nx = S_ACK_LO;
                end else if (cnt >= TO_LAST) begin
                    state_nx = S_LATCH;
                    err_nx   = 1'b1;
                    cnt_nx   = CNT_ONE;
                end else begin
                    cnt_nx = cnt + CNT_ONE;
                end
            end
            S_ACK_LO: begin
                if (!pixel_busy) begin
                    if (idx == LAST_IDX) begin
                        state_nx = S_LATCH;
                        cnt_nx   = CNT_ONE;
                    end else begin
                        state_nx = S_LOAD;
                        idx_nx   = idx + ADDR_W'(1);
                    end
                end
            end
            S_LATCH: begin
                if (cnt >= LAT_LAST) begin
                    state_nx = S_DONE;
                end else begin
                    cnt_nx = cnt + CNT_ONE;
                end
            end
            S_DONE: begin
                state_nx = S_IDLE;
            end
            default: begin
                state_nx = S_IDLE;
            end
        endcase
    end

    assign frame_busy  = (state != S_IDLE) && (state != S_DONE);
    assign done        = (state == S_DONE);
    assign pixel_valid = (state == S_PRESENT);
    assign pixel_r     = pix_q[23:16];
    assign pixel_g     = pix_q[15:8];
    assign pixel_b     = pix_q[7:0];

endmodule

// File: tb/tb_pixel_frame_sequencer.sv
// Randomised bench for pixel_frame_sequencer against a cycle-schedule model.
// Directed frames pin the model with literal latencies and pixel values.
module tb_pixel_frame_sequencer;

    localparam int N   = 8;
    localparam int AW  = 4;
    localparam int LAT = 1200;
    localparam int TO  = 255;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          wr_en = 1'b0;
    logic [AW-1:0] wr_addr = '0;
    logic [23:0]   wr_data = '0;
    logic          start = 1'b0;
    logic          pixel_busy = 1'b0;
    logic          frame_busy;
    logic          done;
    logic          err;
    logic          pixel_valid;
    logic [7:0]    pixel_r;
    logic [7:0]    pixel_g;
    logic [7:0]    pixel_b;

    pixel_frame_sequencer #(
        .NUM_PIXELS  (N),
        .ADDR_W      (AW),
        .LATCH_CYCLES(LAT),
        .BUSY_TIMEOUT(TO)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .wr_en      (wr_en),
        .wr_addr    (wr_addr),
        .wr_data    (wr_data),
        .start      (start),
        .frame_busy (frame_busy),
        .done       (done),
        .err        (err),
        .pixel_valid(pixel_valid),
        .pixel_r    (pixel_r),
        .pixel_g    (pixel_g),
        .pixel_b    (pixel_b),
        .pixel_busy (pixel_busy)
    );

    always #5 clk = ~clk;

    int n_chk = 0;
    int n_fail = 0;
    int cyc = 0;

    // model: buffer image plus the expected event schedule of the frame
    logic [23:0] mem [N];
    logic [23:0] mem_prev [N];
    bit          m_in_frame = 0;
    bit          m_err = 0;
    int          m_idx = 0;
    int          m_next_valid = -1;
    int          m_done = -1;
    int          m_err_cyc = -1;
    logic [23:0] exp_pix = '0;

    // writer behaviour
    bit ack_mode = 1;
    int wd = 3;
    int wl = 20;
    int b_start = 0;
    int b_end = 0;

    // observations
    logic [23:0] valid_log[$];
    int          n_valid = 0;
    int          n_done = 0;
    int          last_done_cyc = -1;
    int          err_rise_cyc = -1;
    logic        err_d = 1'b0;

    task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at cycle %0d",
                     name, act, exp, cyc);
        end
    endtask

    initial begin
        for (int i = 0; i < N; i++) begin
            mem[i]      = '0;
            mem_prev[i] = '0;
        end
    end

    always @(posedge clk) begin : model
        int c;
        int f;
        c = cyc;
        mem_prev = mem;
        if (wr_en && int'(wr_addr) < N) mem[wr_addr[2:0]] = wr_data;
        if (!rst_n) begin
            m_in_frame   = 0;
            m_err        = 0;
            m_next_valid = -1;
            m_done       = -1;
            m_err_cyc    = -1;
        end else begin
            if (c == m_next_valid) begin
                if (ack_mode) begin
                    f = c + wd + wl;
                    if (m_idx == N - 1) begin
                        m_done       = f + LAT;
                        m_next_valid = -1;
                    end else begin
                        m_next_valid = f + 2;
                        m_idx++;
                    end
                end else begin
                    m_err_cyc    = c + TO;
                    m_done       = c + TO - 1 + LAT;
                    m_next_valid = -1;
                end
            end
            if (start && !m_in_frame && c != m_done) begin
                m_in_frame   = 1;
                m_err        = 0;
                m_err_cyc    = -1;
                m_idx        = 0;
                m_next_valid = c + 2;
            end
            if (c + 1 == m_err_cyc) m_err = 1;
            if (c + 1 == m_done) m_in_frame = 0;
        end
        cyc = c + 1;
    end

    always @(negedge clk) begin : compare
        bit ev;
        if (!rst_n) begin
            exp_pix = '0;
            chk("rst_valid", {31'd0, pixel_valid}, 0);
            chk("rst_done", {31'd0, done}, 0);
            chk("rst_fbusy", {31'd0, frame_busy}, 0);
            chk("rst_err", {31'd0, err}, 0);
            chk("rst_pix", {8'd0, pixel_r, pixel_g, pixel_b}, 0);
            b_end = 0;
        end else begin
            ev = (cyc == m_next_valid);
            if (ev) exp_pix = mem_prev[m_idx];
            chk("valid", {31'd0, pixel_valid}, {31'd0, ev});
            chk("done", {31'd0, done}, {31'd0, cyc == m_done});
            chk("frame_busy", {31'd0, frame_busy}, {31'd0, m_in_frame});
            chk("err", {31'd0, err}, {31'd0, m_err});
            chk("pix", {8'd0, pixel_r, pixel_g, pixel_b}, {8'd0, exp_pix});
            if (pixel_valid) begin
                valid_log.push_back({pixel_r, pixel_g, pixel_b});
                n_valid++;
                if (ack_mode) begin
                    b_start = cyc + wd;
                    b_end   = b_start + wl;
                end
            end
            if (done) begin
                n_done++;
                last_done_cyc = cyc;
            end
            if (err && !err_d) err_rise_cyc = cyc;
        end
        err_d = err;
    end

    always @(posedge clk) begin
        #1;
        pixel_busy = rst_n && ack_mode && cyc >= b_start && cyc < b_end;
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wr(int a, logic [23:0] d);
        wr_en   = 1'b1;
        wr_addr = AW'(a);
        wr_data = d;
        tick();
        wr_en = 1'b0;
    endtask

    task automatic pulse_start();
        start = 1'b1;
        tick();
        start = 1'b0;
    endtask

    task automatic wait_frame(string tag);
        int d0;
        int i;
        d0 = n_done;
        i = 0;
        while (n_done == d0 && i < 3000) begin
            tick();
            i++;
        end
        if (n_done == d0) begin
            n_chk++;
            n_fail++;
            $display("FAIL %s_timeout: no done within 3000 cycles", tag);
        end
    endtask

    initial begin : watchdog
        #2000000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin : stim
        int s;
        int base;
        int v0;
        int d0;
        int i;

        // T1: activity while held in reset
        tick();
        tick();
        start   = 1'b1;
        wr_en   = 1'b1;
        wr_addr = 4'd2;
        wr_data = 24'h777777;
        tick();
        start = 1'b0;
        wr_en = 1'b0;
        tick();
        chk("t1_valid", {31'd0, pixel_valid}, 0);
        chk("t1_fbusy", {31'd0, frame_busy}, 0);
        rst_n = 1'b1;
        repeat (3) tick();

        // T2: ramp pattern, writer busy 3 cycles after valid for 20 cycles
        for (int k = 0; k < N; k++) wr(k, 24'h010203 * k);
        ack_mode = 1;
        wd = 3;
        wl = 20;
        base = valid_log.size();
        v0 = n_valid;
        s = cyc;
        pulse_start();
        wait_frame("t2");
        chk("t2_nvalid", n_valid - v0, 8);
        chk("t2_done_cyc", last_done_cyc - s, 1400);
        chk("t2_pix3", {8'd0, valid_log[base + 3]}, 32'h030609);
        chk("t2_pix7", {8'd0, valid_log[base + 7]}, 32'h070e15);
        repeat (5) tick();

        // T3: writer never answers
        ack_mode = 0;
        s = cyc;
        pulse_start();
        wait_frame("t3");
        chk("t3_err_cyc", err_rise_cyc - s, 257);
        chk("t3_done_cyc", last_done_cyc - s, 1456);
        repeat (3) tick();
        chk("t3_err_sticky", {31'd0, err}, 1);
        ack_mode = 1;
        wd = 2;
        wl = 3;
        pulse_start();
        chk("t3_err_clr", {31'd0, err}, 0);
        wait_frame("t3b");
        repeat (3) tick();

        // T4: starts while busy and in the done cycle are ignored
        wd = 1;
        wl = 2;
        v0 = n_valid;
        d0 = n_done;
        pulse_start();
        for (int k = 0; k < 6; k++) begin
            repeat ($urandom_range(1, 10)) tick();
            pulse_start();
        end
        i = 0;
        while (cyc != m_done && i < 3000) begin
            tick();
            i++;
        end
        pulse_start();
        repeat (20) tick();
        chk("t4_nvalid", n_valid - v0, 8);
        chk("t4_ndone", n_done - d0, 1);
        chk("t4_fbusy", {31'd0, frame_busy}, 0);

        // T5: late rewrite of pixel 5 and an out-of-range write
        wd = 2;
        wl = 4;
        base = valid_log.size();
        pulse_start();
        wr(5, 24'hffffff);
        wr(8, 24'h123456);
        wait_frame("t5");
        chk("t5_pix5", {8'd0, valid_log[base + 5]}, 32'h00ffffff);
        chk("t5_pix0", {8'd0, valid_log[base]}, 32'h0);
        repeat (3) tick();

        // T6: reset in the middle of pixel 3
        wr(0, 24'ha5c33c);
        wd = 3;
        wl = 20;
        v0 = n_valid;
        d0 = n_done;
        pulse_start();
        i = 0;
        while (n_valid - v0 < 4 && i < 500) begin
            tick();
            i++;
        end
        tick();
        tick();
        rst_n = 1'b0;
        repeat (3) tick();
        rst_n = 1'b1;
        repeat (30) tick();
        chk("t6_nvalid", n_valid - v0, 4);
        chk("t6_ndone", n_done - d0, 0);
        base = valid_log.size();
        pulse_start();
        wait_frame("t6");
        chk("t6_pix0", {8'd0, valid_log[base]}, 32'h00a5c33c);
        chk("t6_pix5", {8'd0, valid_log[base + 5]}, 32'h00ffffff);
        repeat (3) tick();

        // randomised frames with traffic on every input
        for (int fr = 0; fr < 6; fr++) begin
            ack_mode = ($urandom % 5) != 0;
            wd = $urandom_range(1, 6);
            wl = $urandom_range(1, 8);
            d0 = n_done;
            pulse_start();
            i = 0;
            while (n_done == d0 && i < 3000) begin
                wr_en   = ($urandom % 4) == 0;
                wr_addr = AW'($urandom_range(0, 9));
                wr_data = 24'($urandom);
                start   = (m_in_frame || cyc == m_done) && ($urandom % 16 == 0);
                tick();
                i++;
            end
            wr_en = 1'b0;
            start = 1'b0;
            if (n_done == d0) begin
                n_chk++;
                n_fail++;
                $display("FAIL rand_timeout: frame %0d never finished", fr);
            end
            repeat ($urandom_range(1, 4)) tick();
        end

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_chk, n_fail);
        $finish;
    end

endmodule
